commit_trace_fifo: RTL and testbench
====================================

Name: commit_trace_fifo

Overview:
- Consumes the CPU commit bus (commit, commit_pc, commit_inst, commit_halt, reg/dmem write info) directly downstream of the WB-stage commit registers.
- Buffers each committed instruction as one record in a FIFO.
- A debug host or testbench drains records over a valid/ready port.
- Also counts committed and dropped instructions, and freezes capture after a halt instruction commits.

Parameters:
- DEPTH, 16, number of records; must be a power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- global_en  input  1  CPU global enable; capture is qualified by it
- clr  input  1  synchronous soft clear; same effect as rst
- commit  input  1  commit record valid
- commit_pc  input  32  committed PC
- commit_inst  input  32  committed instruction
- commit_halt  input  1  committed instruction is halt (0x80000000)
- commit_reg_we  input  1  register-file write enable
- commit_reg_wa  input  5  register-file write address
- commit_reg_wd  input  32  register-file write data
- commit_dmem_we  input  1  data-memory write enable
- commit_dmem_wa  input  32  data-memory write address
- commit_dmem_wd  input  32  data-memory write data
- out_valid  output  1  head record available
- out_ready  input  1  consumer accepts head record
- out_pc, out_inst, out_reg_wd, out_dmem_wa, out_dmem_wd  output  32 each  head record fields
- out_reg_wa  output  5  head record field
- out_reg_we, out_dmem_we, out_halt  output  1 each  head record fields
- count  output  AW+1  records currently stored
- inst_count  output  32  total accepted commit records
- drop_count  output  16  commits lost because the FIFO was full
- overflow  output  1  sticky; a commit was dropped
- halted  output  1  halt record has been captured

Behaviour:
- Reset/clear:
  - rst or clr high at a clock edge empties the FIFO (read/write pointers 0, count 0).
  - Zeroes inst_count, drop_count, overflow and halted.
  - All out_* record fields read 0 while the FIFO is empty after reset; out_valid=0.
  - rst takes priority over every other event in the same cycle, including push and pop.
- Capture condition: cap = commit & global_en & ~halted.
- Push:
  - When cap and (count<DEPTH or pop this cycle), write the record at wptr and advance wptr modulo DEPTH.
  - inst_count increments by 1 and wraps at 2^32.
- Drop:
  - When cap, count==DEPTH and no pop this cycle, discard the record.
  - overflow<=1; drop_count increments, saturating at 0xFFFF.
  - inst_count is not incremented.
- Halt:
  - A captured record with commit_halt=1 is pushed normally; halted<=1 on the same edge.
  - If that halt record is dropped, halted is still set.
  - Later commits are ignored until rst/clr; reads continue normally.
- Pop:
  - pop = out_valid & out_ready; advance rptr modulo DEPTH.
  - Output is first-word-fall-through: out_* combinationally shows mem[rptr].
  - out_valid = (count!=0). Fields are don't-care when out_valid=0, except after reset as stated above.
- Simultaneous push and pop:
  - Count is unchanged. Allowed at full: the new record goes into the freed slot with no drop.
  - At empty, a pop cannot occur; push only, and the record appears with out_valid on the next cycle (1-cycle latency).
- Pointers: count = wptr_ext - rptr_ext, using AW+1-bit extended pointers, so full and empty are distinguishable.
- global_en low: no capture, which prevents double capture of held commit registers. Pops still proceed.
- Handshake: the consumer may hold out_ready high continuously. The record must remain stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: COMMIT_TRACE_STAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter increments every clk where global_en=1; it is zeroed by rst/clr.
  - Each captured record stores the counter value sampled at capture.
  - The value is exposed on an extra output port out_stamp (32-bit).
- When undefined: no counter, no out_stamp port, no extra storage.

Test Plan:
- Reset, then 3 commits (pc 0x1c000000, 0x1c000004, 0x1c000008) with global_en=1 and out_ready=0 -> count=3, inst_count=3, out_pc=0x1c000000, out_valid=1.
- Drain with out_ready=1 -> out_pc sequence 0x1c000000, 0x1c000004, 0x1c000008, then out_valid=0 and count=0.
- DEPTH=16 filled with 16 commits, then 2 more with out_ready=0 -> count=16, drop_count=2, overflow=1, inst_count=16.
- At full, one commit with out_ready=1 in the same cycle -> count stays 16, drop_count unchanged, new record read last after 15 older ones.
- Commit with commit_halt=1 and commit_inst=0x80000000, followed by 4 commits -> halted=1, inst_count stops at its value after the halt record, last drained record has out_halt=1.
- commit held high for 5 cycles with global_en=1 only in cycle 2 -> exactly 1 record captured; then clr=1 -> count=0, inst_count=0, halted=0, overflow=0.

Source files
------------

// File: rtl/commit_trace_if.sv
// Commit-trace bus: CPU commit record in, FIFO head record and status out.
// With COMMIT_TRACE_STAMP_EN defined the head record also carries out_stamp.
interface commit_trace_if #(
  parameter int AW = 4
);
  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_halt;
  logic        commit_reg_we;
  logic [4:0]  commit_reg_wa;
  logic [31:0] commit_reg_wd;
  logic        commit_dmem_we;
  logic [31:0] commit_dmem_wa;
  logic [31:0] commit_dmem_wd;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_reg_wd;
  logic [31:0] out_dmem_wa;
  logic [31:0] out_dmem_wd;
  logic [4:0]  out_reg_wa;
  logic        out_reg_we;
  logic        out_dmem_we;
  logic        out_halt;
`ifdef COMMIT_TRACE_STAMP_EN
  logic [31:0] out_stamp;
`endif

  logic [AW:0] count;
  logic [31:0] inst_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        halted;

  // FIFO side: takes the commit bus, presents the head record and status
  modport slave (
`ifdef COMMIT_TRACE_STAMP_EN
    output out_stamp,
`endif
    input  commit, commit_pc, commit_inst, commit_halt, commit_reg_we,
    input  commit_reg_wa, commit_reg_wd, commit_dmem_we, commit_dmem_wa,
    input  commit_dmem_wd, out_ready,
    output out_valid, out_pc, out_inst, out_reg_wd, out_dmem_wa, out_dmem_wd,
    output out_reg_wa, out_reg_we, out_dmem_we, out_halt,
    output count, inst_count, drop_count, overflow, halted
  );

  // CPU/host side: drives the commit bus, drains the head record
  modport master (
`ifdef COMMIT_TRACE_STAMP_EN
    input  out_stamp,
`endif
    output commit, commit_pc, commit_inst, commit_halt, commit_reg_we,
    output commit_reg_wa, commit_reg_wd, commit_dmem_we, commit_dmem_wa,
    output commit_dmem_wd, out_ready,
    input  out_valid, out_pc, out_inst, out_reg_wd, out_dmem_wa, out_dmem_wd,
    input  out_reg_wa, out_reg_we, out_dmem_we, out_halt,
    input  count, inst_count, drop_count, overflow, halted
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: buffers each committed instruction as one record,
// drained first-word-fall-through over a valid/ready port. Counts accepted
// and dropped commits; capture freezes once a halt instruction commits.
// Optional macro COMMIT_TRACE_STAMP_EN adds a per-record cycle stamp.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic global_en,
  input  logic clr,
  commit_trace_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
`ifdef COMMIT_TRACE_STAMP_EN
    logic [31:0] stamp;
`endif
  } rec_t;

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rec_t        mem [DEPTH];
  rec_t        wr_rec;
  rec_t        head;
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] cnt;
  logic [31:0] inst_cnt;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic        hlt;
  logic        cap;
  logic        pop;
  logic        push;
  logic        drop;
  logic        full;
  logic        valid;
`ifdef COMMIT_TRACE_STAMP_EN
  logic [31:0] cycle_cnt;
`endif

  // Handshake and capture qualification
  always_comb begin
    cnt   = wptr - rptr;
    full  = (cnt == FULL_CNT);
    valid = (cnt != '0);
    pop   = valid & bus.out_ready;
    cap   = bus.commit & global_en & ~hlt;
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
  end

  // Assemble the record to store from the commit bus
  always_comb begin
    wr_rec         = '0;
    wr_rec.pc      = bus.commit_pc;
    wr_rec.inst    = bus.commit_inst;
    wr_rec.halt    = bus.commit_halt;
    wr_rec.reg_we  = bus.commit_reg_we;
    wr_rec.reg_wa  = bus.commit_reg_wa;
    wr_rec.reg_wd  = bus.commit_reg_wd;
    wr_rec.dmem_we = bus.commit_dmem_we;
    wr_rec.dmem_wa = bus.commit_dmem_wa;
    wr_rec.dmem_wd = bus.commit_dmem_wd;
`ifdef COMMIT_TRACE_STAMP_EN
    wr_rec.stamp   = cycle_cnt;
`endif
  end

  // Record storage; no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_rec;
  end

  // Pointers, counters and sticky status; rst/clr win over everything
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr     <= '0;
      rptr     <= '0;
      inst_cnt <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
      hlt      <= 1'b0;
    end else begin
      if (push) begin
        wptr     <= wptr + PTR_ONE;
        inst_cnt <= inst_cnt + 32'd1;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      // a halt freezes capture even if its own record was dropped
      if (cap && bus.commit_halt) hlt <= 1'b1;
    end
  end

`ifdef COMMIT_TRACE_STAMP_EN
  // Free-running cycle stamp, advancing only while the CPU is enabled
  always_ff @(posedge clk) begin
    if (rst || clr)     cycle_cnt <= '0;
    else if (global_en) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // Fall-through head; fields forced to 0 whenever the FIFO is empty
  always_comb begin
    head             = valid ? mem[rptr[AW-1:0]] : '0;
    bus.out_valid    = valid;
    bus.out_pc       = head.pc;
    bus.out_inst     = head.inst;
    bus.out_halt     = head.halt;
    bus.out_reg_we   = head.reg_we;
    bus.out_reg_wa   = head.reg_wa;
    bus.out_reg_wd   = head.reg_wd;
    bus.out_dmem_we  = head.dmem_we;
    bus.out_dmem_wa  = head.dmem_wa;
    bus.out_dmem_wd  = head.dmem_wd;
`ifdef COMMIT_TRACE_STAMP_EN
    bus.out_stamp    = head.stamp;
`endif
    bus.count        = cnt;
    bus.inst_count   = inst_cnt;
    bus.drop_count   = drop_cnt;
    bus.overflow     = ovf;
    bus.halted       = hlt;
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (DEPTH=16).
module tb_commit_trace_fifo;
  logic clk = 1'b0;
  logic rst;
  logic global_en;
  logic clr;
  int   n_run  = 0;
  int   n_fail = 0;

  commit_trace_if #(.AW(4)) bus ();

  commit_trace_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .global_en(global_en), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  // one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commit = 0; bus.commit_pc = 0; bus.commit_inst = 0; bus.commit_halt = 0;
    bus.commit_reg_we = 0; bus.commit_reg_wa = 0; bus.commit_reg_wd = 0;
    bus.commit_dmem_we = 0; bus.commit_dmem_wa = 0; bus.commit_dmem_wd = 0;
    bus.out_ready = 0;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic halt);
    bus.commit      = 1;
    bus.commit_pc   = pc;
    bus.commit_inst = halt ? 32'h80000000 : (pc ^ 32'h00000013);
    bus.commit_halt = halt;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); clr = 0; global_en = 1;
    do_reset();
    n_run++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_run++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0 || bus.out_halt !== 1'b0)
      begin n_fail++; $display("FAIL reset_fields got pc=%h inst=%h halt=%b want 0", bus.out_pc, bus.out_inst, bus.out_halt); end
    n_run++; if (bus.inst_count !== 0 || bus.drop_count !== 0 || bus.overflow !== 0 || bus.halted !== 0)
      begin n_fail++; $display("FAIL reset_status got ic=%0d dc=%0d ovf=%b h=%b want 0", bus.inst_count, bus.drop_count, bus.overflow, bus.halted); end
  endtask

  task automatic test_rst_priority();
    do_reset();
    set_commit(32'h00000040, 0); step();
    // commit, pop and rst all in one cycle: rst wins
    set_commit(32'h00000044, 1); bus.out_ready = 1; rst = 1; step();
    rst = 0; idle_inputs();
    n_run++; if (bus.count !== 5'd0 || bus.inst_count !== 0 || bus.halted !== 0)
      begin n_fail++; $display("FAIL rst_priority got cnt=%0d ic=%0d h=%b want 0 0 0", bus.count, bus.inst_count, bus.halted); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin set_commit(32'h1c000000 + 32'(4*i), 0); step(); end
    idle_inputs();
    n_run++; if (bus.count !== 5'd3 || bus.inst_count !== 32'd3)
      begin n_fail++; $display("FAIL basic_count got cnt=%0d ic=%0d want 3 3", bus.count, bus.inst_count); end
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1c000000)
      begin n_fail++; $display("FAIL basic_head got v=%b pc=%h want 1 1c000000", bus.out_valid, bus.out_pc); end
    step(); step();
    n_run++; if (bus.out_pc !== 32'h1c000000 || bus.out_inst !== 32'h1c000013)
      begin n_fail++; $display("FAIL basic_stable got pc=%h inst=%h want 1c000000 1c000013", bus.out_pc, bus.out_inst); end
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h1c000000 + 32'(4*i);
      n_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc)
        begin n_fail++; $display("FAIL basic_drain%0d got v=%b pc=%h want 1 %h", i, bus.out_valid, bus.out_pc, exp_pc); end
      step();
    end
    bus.out_ready = 0;
    n_run++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd0)
      begin n_fail++; $display("FAIL basic_empty got v=%b cnt=%0d want 0 0", bus.out_valid, bus.count); end
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [31:0] exp_pc;
    int bad;
    do_reset();
    for (int i = 0; i < 18; i++) begin set_commit(32'h00000100 + 32'(4*i), 0); step(); end
    idle_inputs();
    n_run++; if (bus.count !== 5'd16 || bus.drop_count !== 16'd2 || bus.overflow !== 1'b1 || bus.inst_count !== 32'd16)
      begin n_fail++; $display("FAIL overflow got cnt=%0d dc=%0d ovf=%b ic=%0d want 16 2 1 16", bus.count, bus.drop_count, bus.overflow, bus.inst_count); end
    // push and pop together while full: no drop, count unchanged
    set_commit(32'h00000abc, 0); bus.out_ready = 1; step();
    idle_inputs();
    n_run++; if (bus.count !== 5'd16 || bus.drop_count !== 16'd2 || bus.inst_count !== 32'd17)
      begin n_fail++; $display("FAIL full_pushpop got cnt=%0d dc=%0d ic=%0d want 16 2 17", bus.count, bus.drop_count, bus.inst_count); end
    bad = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      exp_pc = (i == 15) ? 32'h00000abc : 32'h00000104 + 32'(4*i);
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin
        bad++; $display("FAIL full_drain%0d got v=%b pc=%h want 1 %h", i, bus.out_valid, bus.out_pc, exp_pc);
      end
      step();
    end
    bus.out_ready = 0;
    n_run++; if (bad != 0) n_fail++;
    n_run++; if (bus.out_valid !== 1'b0 || bus.count !== 5'd0)
      begin n_fail++; $display("FAIL full_empty got v=%b cnt=%0d want 0 0", bus.out_valid, bus.count); end
  endtask

  task automatic test_halt();
    do_reset();
    set_commit(32'h00000200, 0); step();
    set_commit(32'h00000204, 1); step();
    for (int i = 0; i < 4; i++) begin set_commit(32'h00000208 + 32'(4*i), 0); step(); end
    idle_inputs();
    n_run++; if (bus.halted !== 1'b1 || bus.inst_count !== 32'd2 || bus.count !== 5'd2)
      begin n_fail++; $display("FAIL halt_freeze got h=%b ic=%0d cnt=%0d want 1 2 2", bus.halted, bus.inst_count, bus.count); end
    bus.out_ready = 1;
    n_run++; if (bus.out_pc !== 32'h00000200 || bus.out_halt !== 1'b0)
      begin n_fail++; $display("FAIL halt_rec0 got pc=%h halt=%b want 00000200 0", bus.out_pc, bus.out_halt); end
    step();
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h00000204 || bus.out_halt !== 1'b1 || bus.out_inst !== 32'h80000000)
      begin n_fail++; $display("FAIL halt_rec1 got v=%b pc=%h halt=%b inst=%h want 1 00000204 1 80000000", bus.out_valid, bus.out_pc, bus.out_halt, bus.out_inst); end
    step();
    bus.out_ready = 0;
    n_run++; if (bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL halt_empty got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_global_en_clr();
    do_reset();
    global_en = 0;
    set_commit(32'h00000300, 0);
    for (int i = 0; i < 5; i++) begin global_en = (i == 1); step(); end
    global_en = 1; idle_inputs();
    n_run++; if (bus.count !== 5'd1 || bus.inst_count !== 32'd1 || bus.out_pc !== 32'h00000300)
      begin n_fail++; $display("FAIL gen_capture got cnt=%0d ic=%0d pc=%h want 1 1 00000300", bus.count, bus.inst_count, bus.out_pc); end
    // overfill by one, then a halt that is itself dropped
    for (int i = 0; i < 16; i++) begin set_commit(32'h00000400 + 32'(4*i), 0); step(); end
    set_commit(32'h00000500, 1); step();
    set_commit(32'h00000504, 0); step();
    idle_inputs();
    n_run++; if (bus.halted !== 1'b1 || bus.drop_count !== 16'd2 || bus.inst_count !== 32'd16 || bus.overflow !== 1'b1)
      begin n_fail++; $display("FAIL dropped_halt got h=%b dc=%0d ic=%0d ovf=%b want 1 2 16 1", bus.halted, bus.drop_count, bus.inst_count, bus.overflow); end
    clr = 1; step(); clr = 0;
    n_run++; if (bus.count !== 5'd0 || bus.inst_count !== 0 || bus.halted !== 0 || bus.overflow !== 0 || bus.drop_count !== 0)
      begin n_fail++; $display("FAIL clr got cnt=%0d ic=%0d h=%b ovf=%b dc=%0d want 0", bus.count, bus.inst_count, bus.halted, bus.overflow, bus.drop_count); end
    n_run++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0)
      begin n_fail++; $display("FAIL clr_out got v=%b pc=%h want 0 0", bus.out_valid, bus.out_pc); end
    // capture works again after clr
    set_commit(32'h00000600, 0); step(); idle_inputs();
    n_run++; if (bus.count !== 5'd1 || bus.out_pc !== 32'h00000600)
      begin n_fail++; $display("FAIL clr_recapture got cnt=%0d pc=%h want 1 00000600", bus.count, bus.out_pc); end
  endtask

  initial begin
    rst = 1; clr = 0; global_en = 1;
    idle_inputs();
    test_reset();
    test_rst_priority();
    test_basic();
    test_overflow_and_full_pushpop();
    test_halt();
    test_global_en_clr();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
